// File: rtl/video_raster_gen.sv
// Raster timing and interrupt generator for the SAM Coupe video path.
// Pixel/line counters, blank/sync strobes, fetch window, CPU contention,
// flash phase, light-pen latches and programmable line interrupts.

// One line-interrupt channel: compare register plus a sticky pending bit.
module video_raster_int_ch #(
  parameter int V_DISP = 192
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       sol,      // ce_6mn at hc==0 (start of line)
  input  logic       wr,       // edge-qualified write for this channel
  input  logic       ack,      // edge-qualified acknowledge for this channel
  input  logic [8:0] vc,
  input  logic [8:0] din,
  output logic       pend
);
  localparam logic [8:0] VD = 9'(V_DISP);

  logic [8:0] cmp;
  logic       hit;

  // A compare value outside the active area (incl. 9'h1FF) never fires.
  assign hit = sol && (cmp < VD) && (vc == cmp);

  // Compare register and pending bit; disabling wins, then set beats ack.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cmp  <= 9'h1FF;
      pend <= 1'b0;
    end else begin
      if (wr) cmp <= din;
      if (wr && din == 9'h1FF) pend <= 1'b0;
      else if (hit)            pend <= 1'b1;
      else if (ack)            pend <= 1'b0;
    end
  end
endmodule

module video_raster_gen #(
  parameter int H_TOTAL   = 384,
  parameter int V_TOTAL   = 312,
  parameter int H_DISP    = 128,
  parameter int V_DISP    = 192,
  parameter int HBL_START = 28,
  parameter int HS_START  = 44,
  parameter int HS_END    = 76,
  parameter int HBL_END   = 108,
  parameter int VBL_START = 236,
  parameter int VS_START  = 240,
  parameter int VS_END    = 244,
  parameter int VBL_END   = 260,
  parameter int INT_CH    = 2,
  parameter int INT_LEN   = 128,
  parameter int CPU_SLOT  = 5,
  localparam int SEL_W    = (INT_CH > 1) ? $clog2(INT_CH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_6mp,
  input  logic              ce_6mn,
  input  logic [1:0]        fetch_mode,
  input  logic              full_zx,
  input  logic              soff,
  input  logic              int_we,
  input  logic [SEL_W-1:0]  int_sel,
  input  logic [8:0]        int_din,
  input  logic              int_ack,
  output logic [8:0]        hc,
  output logic [8:0]        vc,
  output logic              hblank,
  output logic              hsync,
  output logic              vblank,
  output logic              vsync,
  output logic              fetch,
  output logic              mem_contention,
  output logic              io_contention,
  output logic              int_line,
  output logic [INT_CH-1:0] int_pend,
  output logic              int_frame,
  output logic              flash,
  output logic [4:0]        lpen_col,
  output logic [7:0]        hpen
);
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] HD     = 9'(H_DISP);
  localparam logic [8:0] VD     = 9'(V_DISP);
  localparam logic [8:0] HBL_S  = 9'(HBL_START);
  localparam logic [8:0] HBL_E  = 9'(HBL_END);
  localparam logic [8:0] HS_S   = 9'(HS_START);
  localparam logic [8:0] HS_E   = 9'(HS_END);
  localparam logic [8:0] VBL_S  = 9'(VBL_START);
  localparam logic [8:0] VBL_E  = 9'(VBL_END);
  localparam logic [8:0] VS_S   = 9'(VS_START);
  localparam logic [8:0] VS_E   = 9'(VS_END);
  localparam logic [8:0] ILEN   = 9'(INT_LEN);
  localparam logic [2:0] SLOT   = 3'(CPU_SLOT);

  logic [4:0]        frame_cnt;
  logic              int_we_q, int_ack_q;
  logic              we_rise, ack_rise, sel_ok, sol;
  logic              relief_off;
  logic [INT_CH-1:0] ch_wr, ch_ack;

  // Pixel/line counters and frame counter, advanced on ce_6mp.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
    end else if (ce_6mp) begin
      if (hc == H_LAST) begin
        hc <= '0;
        if (vc == V_LAST) begin
          vc        <= '0;
          frame_cnt <= frame_cnt + 5'd1;
        end else begin
          vc <= vc + 9'd1;
        end
      end else begin
        hc <= hc + 9'd1;
      end
    end
  end

  assign flash = frame_cnt[4];

  // Raster strobes and frame interrupt, registered one ce_6mn after the match.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hblank    <= 1'b0;
      hsync     <= 1'b0;
      vblank    <= 1'b0;
      vsync     <= 1'b0;
      int_frame <= 1'b0;
    end else if (ce_6mn) begin
      if (hc == HBL_S) hblank <= 1'b1;
      if (hc == HBL_E) hblank <= 1'b0;
      if (hc == HS_S)  hsync  <= 1'b1;
      if (hc == HS_E)  hsync  <= 1'b0;
      if (vc == VS_S)  vsync  <= 1'b1;
      if (vc == VS_E)  vsync  <= 1'b0;
      if (hc == HBL_S && vc == VBL_S) vblank <= 1'b1;
      if (hc == HBL_E && vc == VBL_E) vblank <= 1'b0;
      int_frame <= (vc == VS_E) && (hc < ILEN);
    end
  end

  // Fetch window: re-armed on every 8-pixel group boundary of the active area.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      fetch <= 1'b0;
    end else if (ce_6mn) begin
      if (hc == 9'd0)
        fetch <= 1'b0;
      else if (hc >= HD && vc < VD && hc[2:0] == 3'd0)
        fetch <= ~soff;
    end
  end

  // The CPU gets one slot per 8-pixel group while the display fetches (or in
  // the right half of a mode-0 border unless full_zx), otherwise one per four.
  assign io_contention  = (hc[2:0] != SLOT);
  assign relief_off     = fetch | ((fetch_mode == 2'd0) & ~full_zx & hc[6]);
  assign mem_contention = relief_off ? (hc[2:0] != SLOT) : (hc[1:0] != SLOT[1:0]);

  // Light-pen latches, sampled only on the CPU slot.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      lpen_col <= '0;
      hpen     <= '0;
    end else if (ce_6mn && !io_contention) begin
      lpen_col <= fetch ? {~hc[7], hc[6:3]} : 5'd0;
      hpen     <= (soff || vc > VD) ? VD[7:0] : vc[7:0];
    end
  end

  // Edge detectors for the level-sensitive write and acknowledge strobes.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      int_we_q  <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      int_we_q  <= int_we;
      int_ack_q <= int_ack;
    end
  end

  assign we_rise  = int_we & ~int_we_q;
  assign ack_rise = int_ack & ~int_ack_q;
  assign sel_ok   = 32'(int_sel) < INT_CH;
  assign sol      = ce_6mn && (hc == 9'd0);

  for (genvar k = 0; k < INT_CH; k++) begin : g_ch
    assign ch_wr[k]  = we_rise  & sel_ok & (int_sel == SEL_W'(k));
    assign ch_ack[k] = ack_rise & sel_ok & (int_sel == SEL_W'(k));

    video_raster_int_ch #(.V_DISP(V_DISP)) u_ch (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .sol     (sol),
      .wr      (ch_wr[k]),
      .ack     (ch_ack[k]),
      .vc      (vc),
      .din     (int_din),
      .pend    (int_pend[k])
    );
  end

  assign int_line = |int_pend;
endmodule

// File: tb/tb_video_raster_gen.sv
// Scoreboard bench for video_raster_gen on a shrunken raster (80x32) so that
// 16+ frames fit in a short run. Expectations are queued at each probe point
// and popped against the live outputs.
module tb_video_raster_gen;
  localparam int HT = 80, VT = 32;

  logic       clk_sys = 1'b0;
  logic       reset_n, ce_6mp, ce_6mn, full_zx, soff, int_we, int_ack;
  logic [1:0] fetch_mode;
  logic [0:0] int_sel;
  logic [8:0] int_din;
  logic [8:0] hc, vc;
  logic       hblank, hsync, vblank, vsync, fetch, mem_contention, io_contention;
  logic       int_line, int_frame, flash;
  logic [1:0] int_pend;
  logic [4:0] lpen_col;
  logic [7:0] hpen;

  video_raster_gen #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_DISP(32), .V_DISP(16),
    .HBL_START(4), .HS_START(8), .HS_END(12), .HBL_END(20),
    .VBL_START(20), .VS_START(22), .VS_END(24), .VBL_END(28),
    .INT_CH(2), .INT_LEN(16), .CPU_SLOT(5)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_6mp(ce_6mp), .ce_6mn(ce_6mn),
    .fetch_mode(fetch_mode), .full_zx(full_zx), .soff(soff),
    .int_we(int_we), .int_sel(int_sel), .int_din(int_din), .int_ack(int_ack),
    .hc(hc), .vc(vc), .hblank(hblank), .hsync(hsync), .vblank(vblank),
    .vsync(vsync), .fetch(fetch), .mem_contention(mem_contention),
    .io_contention(io_contention), .int_line(int_line), .int_pend(int_pend),
    .int_frame(int_frame), .flash(flash), .lpen_col(lpen_col), .hpen(hpen)
  );

  always #5 clk_sys = ~clk_sys;

  localparam int S_HC = 0, S_VC = 1, S_HBL = 2, S_HS = 3, S_VBL = 4, S_VS = 5,
                 S_FETCH = 6, S_MEM = 7, S_IO = 8, S_INTL = 9, S_PEND = 10,
                 S_IFR = 11, S_FLASH = 12, S_LPEN = 13, S_HPEN = 14;

  typedef struct {
    string       tag;
    int          id;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_err = 0;
  int   mhc = 0, mvc = 0, mfr = 0;  // bench raster position (ce_6mp count)
  int   tf = 0;                     // frame the next probes refer to

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @hc=%0d vc=%0d fr=%0d: got %0h want %0h", tag, mhc, mvc, mfr, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int id);
    case (id)
      S_HC:    return 32'(hc);
      S_VC:    return 32'(vc);
      S_HBL:   return 32'(hblank);
      S_HS:    return 32'(hsync);
      S_VBL:   return 32'(vblank);
      S_VS:    return 32'(vsync);
      S_FETCH: return 32'(fetch);
      S_MEM:   return 32'(mem_contention);
      S_IO:    return 32'(io_contention);
      S_INTL:  return 32'(int_line);
      S_PEND:  return 32'(int_pend);
      S_IFR:   return 32'(int_frame);
      S_FLASH: return 32'(flash);
      S_LPEN:  return 32'(lpen_col);
      S_HPEN:  return 32'(hpen);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int id, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.id = id; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(e.id), e.exp);
    end
  endtask

  // One clock; the bench tracks where the raster must be afterwards.
  task automatic step();
    logic r, p;
    r = reset_n; p = ce_6mp;
    @(posedge clk_sys);
    if (!r) begin
      mhc = 0; mvc = 0; mfr = 0;
    end else if (p) begin
      if (mhc == HT - 1) begin
        mhc = 0;
        if (mvc == VT - 1) begin mvc = 0; mfr++; end
        else mvc++;
      end else mhc++;
    end
    #1;
  endtask

  task automatic run_to(input int h, input int v, input int f);
    int n;
    n = 0;
    while (!(mhc == h && mvc == v && mfr == f) && n < 60000) begin
      step();
      n++;
    end
    if (n >= 60000) chk("run_to_timeout", 32'(n), 32'(59999));
  endtask

  task automatic at(input int h, input int v, input string tag, input int id, input logic [31:0] val);
    run_to(h, v, tf);
    push(tag, id, val);
    settle();
  endtask

  task automatic wr_cmp(input logic sel, input logic [8:0] val);
    int_sel = sel; int_din = val; int_we = 1'b1;
    step();
    int_we = 1'b0;
    step();
  endtask

  task automatic ack_ch(input logic sel);
    int_sel = sel; int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    step();
  endtask

  task automatic push_reset_state();
    push("rst_hc", S_HC, 0);       push("rst_vc", S_VC, 0);
    push("rst_hblank", S_HBL, 0);  push("rst_hsync", S_HS, 0);
    push("rst_vblank", S_VBL, 0);  push("rst_vsync", S_VS, 0);
    push("rst_fetch", S_FETCH, 0); push("rst_pend", S_PEND, 0);
    push("rst_int_line", S_INTL, 0); push("rst_int_frame", S_IFR, 0);
    push("rst_flash", S_FLASH, 0); push("rst_lpen", S_LPEN, 0);
    push("rst_hpen", S_HPEN, 0);   push("rst_io", S_IO, 1);
    push("rst_mem", S_MEM, 1);
    settle();
  endtask

  initial begin
    reset_n = 1'b0; ce_6mp = 1'b1; ce_6mn = 1'b1; fetch_mode = 2'd0;
    full_zx = 1'b0; soff = 1'b0; int_we = 1'b0; int_sel = 1'b0;
    int_din = 9'd0; int_ack = 1'b0;
    step(); step();
    push_reset_state();
    reset_n = 1'b1;

    // Frame 0: horizontal strobes, fetch window, light pen, line interrupts.
    tf = 0;
    at(4, 0, "hblank_pre", S_HBL, 0);   at(5, 0, "hblank_on", S_HBL, 1);
    at(8, 0, "hsync_pre", S_HS, 0);     at(9, 0, "hsync_on", S_HS, 1);
    at(12, 0, "hsync_last", S_HS, 1);   at(13, 0, "hsync_off", S_HS, 0);
    at(20, 0, "hblank_last", S_HBL, 1); at(21, 0, "hblank_off", S_HBL, 0);
    at(32, 0, "fetch_pre", S_FETCH, 0); at(33, 0, "fetch_on", S_FETCH, 1);
    at(0, 1, "fetch_hold", S_FETCH, 1); at(1, 1, "fetch_clr", S_FETCH, 0);
    run_to(2, 1, tf);
    wr_cmp(1'b0, 9'd5);
    wr_cmp(1'b1, 9'd10);
    at(38, 2, "lpen_col_37", S_LPEN, 32'h14);
    at(38, 2, "hpen_line2", S_HPEN, 2);
    at(78, 2, "lpen_col_77", S_LPEN, 32'h19);
    at(6, 3, "lpen_border", S_LPEN, 0);
    at(6, 3, "hpen_line3", S_HPEN, 3);
    at(0, 5, "pend_pre5", S_PEND, 0);
    at(1, 5, "pend_ch0", S_PEND, 1);
    at(1, 5, "int_line_ch0", S_INTL, 1);
    run_to(10, 5, tf);
    ack_ch(1'b0);
    push("pend_acked", S_PEND, 0); push("int_line_acked", S_INTL, 0); settle();
    at(0, 10, "pend_pre10", S_PEND, 0);
    at(1, 10, "pend_ch1", S_PEND, 2);
    at(1, 10, "int_line_ch1", S_INTL, 1);
    run_to(5, 10, tf);
    ack_ch(1'b1);
    push("pend_ack1", S_PEND, 0); settle();
    at(6, 15, "hpen_last_active", S_HPEN, 15);
    at(4, 20, "vblank_pre", S_VBL, 0);
    at(5, 20, "vblank_on", S_VBL, 1);
    at(6, 20, "hpen_border", S_HPEN, 16);
    for (int h = 64; h < 80; h++) begin
      if (h == 72) full_zx = 1'b1;
      run_to(h, 20, tf);
      push("io_cont", S_IO, 32'(h % 8 != 5));
      push("mem_cont", S_MEM, (h < 72) ? 32'(h % 8 != 5) : 32'(h % 4 != 1));
      settle();
    end
    full_zx = 1'b0;
    at(0, 22, "vsync_pre", S_VS, 0);    at(1, 22, "vsync_on", S_VS, 1);
    at(0, 24, "vsync_last", S_VS, 1);   at(0, 24, "int_frame_pre", S_IFR, 0);
    at(1, 24, "vsync_off", S_VS, 0);    at(1, 24, "int_frame_on", S_IFR, 1);
    at(16, 24, "int_frame_last", S_IFR, 1);
    at(17, 24, "int_frame_off", S_IFR, 0);
    at(20, 28, "vblank_last", S_VBL, 1);
    at(21, 28, "vblank_off", S_VBL, 0);

    // Frame 1: wrap, screen-off line, simultaneous set and acknowledge.
    tf = 1;
    run_to(0, 0, tf);
    push("wrap_hc", S_HC, 0); push("wrap_vc", S_VC, 0); push("flash_f1", S_FLASH, 0); settle();
    run_to(0, 3, tf);
    soff = 1'b1;
    at(33, 3, "soff_fetch33", S_FETCH, 0);
    at(38, 3, "soff_hpen", S_HPEN, 16);
    at(38, 3, "soff_lpen", S_LPEN, 0);
    at(79, 3, "soff_fetch79", S_FETCH, 0);
    soff = 1'b0;
    at(33, 4, "fetch_resume", S_FETCH, 1);
    at(0, 10, "pend_pre_race", S_PEND, 1);
    int_sel = 1'b1; int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    push("set_beats_ack", S_PEND, 3); settle();

    // Flash phase flips after 16 frames.
    tf = 15;
    at(0, 0, "flash_f15", S_FLASH, 0);
    tf = 16;
    at(0, 0, "flash_f16", S_FLASH, 1);
    run_to(2, 11, tf);
    ack_ch(1'b0);
    push("pend_ack0_f16", S_PEND, 2); settle();
    wr_cmp(1'b0, 9'd13);
    at(1, 13, "pend_new_cmp", S_PEND, 3);
    run_to(2, 14, tf);
    wr_cmp(1'b0, 9'h1FF);
    push("pend_disable_clr", S_PEND, 2); settle();

    // Reset in the middle of the vertical sync region.
    run_to(10, 22, tf);
    push("pre_rst_hsync", S_HS, 1); push("pre_rst_vsync", S_VS, 1);
    push("pre_rst_vblank", S_VBL, 1); push("pre_rst_hblank", S_HBL, 1);
    settle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    push_reset_state();
    tf = 0;
    at(1, 5, "post_rst_cmp0", S_PEND, 0);
    at(1, 10, "post_rst_cmp1", S_PEND, 0);
    at(1, 13, "post_rst_line13", S_PEND, 0);
    at(40, 13, "post_rst_vc", S_VC, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
